register_file_write_arbiter: RTL and testbench

Shares the single write port of the 16×16 `register_file` between two writeback sources, port 0 (ALU) and port 1 (load/memory). Each source has a valid/ready handshake into a one-entry holding slot. The arbiter drains at most one slot per cycle onto the register-file write port, oldest entry first, so write order to any register is preserved. It also exports a pending-write mask that the issue logic uses for RAW hazard stalls.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_write_slot.sv | 60 ++++++
 rtl/register_file_write_arbiter.sv | 142 ++++++++++++++
 tb/tb_register_file_write_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared sizing defaults for the 16x16 register file and its
//                write-port arbiter, plus the slot-select type.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  // Register-file sizing shared with register_file
  localparam int W         = 16;
  localparam int ADDR_BITS = 4;
  localparam int NUM_REGS  = 16;

  // Identifies which holding slot owns the write port
  typedef enum logic {
    SLOT0 = 1'b0,
    SLOT1 = 1'b1
  } slot_sel_e;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_write_slot.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_slot
//  Description : One-entry holding buffer for a pending register write.
//                A load wins over a drain in the same cycle, so a slot that
//                is granted can be refilled without a bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_slot #(
  parameter int W         = regfile_pkg::W,
  parameter int ADDR_BITS = regfile_pkg::ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 drain,
  input  logic [ADDR_BITS-1:0] inp_address,
  input  logic [W-1:0]         inp_data,
  output logic                 out_full,
  output logic [ADDR_BITS-1:0] out_address,
  output logic [W-1:0]         out_data
);

  logic                 full_q, full_d;
  logic [ADDR_BITS-1:0] address_q, address_d;
  logic [W-1:0]         data_q, data_d;

  // Next-state: load captures a new entry, drain empties, otherwise hold
  always_comb begin
    full_d    = full_q;
    address_d = address_q;
    data_d    = data_q;
    if (load) begin
      full_d    = 1'b1;
      address_d = inp_address;
      data_d    = inp_data;
    end else if (drain) begin
      full_d    = 1'b0;
    end
  end

  // Slot storage, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q    <= 1'b0;
      address_q <= '0;
      data_q    <= '0;
    end else begin
      full_q    <= full_d;
      address_q <= address_d;
      data_q    <= data_d;
    end
  end

  assign out_full    = full_q;
  assign out_address = address_q;
  assign out_data    = data_q;

endmodule : regfile_write_slot
`default_nettype wire

// File: rtl/register_file_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_write_arbiter
//  Description : Shares the single register-file write port between the ALU
//                (port 0) and load/memory (port 1) writeback sources. Each
//                source fills a one-entry slot; the oldest full slot drains
//                each cycle so per-register write order is kept. Exports a
//                pending-write mask for RAW hazard stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file_write_arbiter #(
  parameter int W         = regfile_pkg::W,
  parameter int ADDR_BITS = regfile_pkg::ADDR_BITS,
  parameter int NUM_REGS  = regfile_pkg::NUM_REGS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inp_valid0,
  output logic                 out_ready0,
  input  logic [ADDR_BITS-1:0] inp_address0,
  input  logic [W-1:0]         inp_data0,
  input  logic                 inp_valid1,
  output logic                 out_ready1,
  input  logic [ADDR_BITS-1:0] inp_address1,
  input  logic [W-1:0]         inp_data1,
  output logic                 out_write_enable,
  output logic [ADDR_BITS-1:0] out_write_address,
  output logic [W-1:0]         out_write_data,
  output logic                 out_grant,
  output logic [NUM_REGS-1:0]  out_pending
);

  import regfile_pkg::*;

  logic                 full0, full1;
  logic [ADDR_BITS-1:0] address0, address1;
  logic [W-1:0]         data0, data1;
  logic                 load0, load1;
  logic                 drain0, drain1;
  logic                 write_enable;
  slot_sel_e            grant_sel;
  logic                 older1_q, older1_d;

  regfile_write_slot #(
    .W         (W),
    .ADDR_BITS (ADDR_BITS)
  ) u_slot0 (
    .clk         (clk),
    .reset       (reset),
    .load        (load0),
    .drain       (drain0),
    .inp_address (inp_address0),
    .inp_data    (inp_data0),
    .out_full    (full0),
    .out_address (address0),
    .out_data    (data0)
  );

  regfile_write_slot #(
    .W         (W),
    .ADDR_BITS (ADDR_BITS)
  ) u_slot1 (
    .clk         (clk),
    .reset       (reset),
    .load        (load1),
    .drain       (drain1),
    .inp_address (inp_address1),
    .inp_data    (inp_data1),
    .out_full    (full1),
    .out_address (address1),
    .out_data    (data1)
  );

  // Grant: a lone full slot wins; with both full, older1 picks the oldest
  always_comb begin
    write_enable = full0 | full1;
    grant_sel    = SLOT0;
    if (full1 && (!full0 || older1_q)) begin
      grant_sel = SLOT1;
    end
    drain0 = write_enable && (grant_sel == SLOT0);
    drain1 = write_enable && (grant_sel == SLOT1);
  end

  // Ready depends only on registered slot state, never on the inputs
  always_comb begin
    out_ready0 = !full0 || drain0;
    out_ready1 = !full1 || drain1;
    load0      = inp_valid0 && out_ready0;
    load1      = inp_valid1 && out_ready1;
  end

  // Age tracking: remember when slot 1 holds an entry older than slot 0's
  always_comb begin
    older1_d = older1_q;
    if (load0 && load1) begin
      older1_d = 1'b0;
    end else if (load0 && full1 && !drain1) begin
      older1_d = 1'b1;
    end else if (load1 && full0 && !drain0) begin
      older1_d = 1'b0;
    end
  end

  // Age bit register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      older1_q <= 1'b0;
    end else begin
      older1_q <= older1_d;
    end
  end

  // Write port driven straight from the granted slot; zeros while idle
  always_comb begin
    out_write_enable  = write_enable;
    out_grant         = 1'b0;
    out_write_address = '0;
    out_write_data    = '0;
    if (drain1) begin
      out_grant         = 1'b1;
      out_write_address = address1;
      out_write_data    = data1;
    end else if (drain0) begin
      out_write_address = address0;
      out_write_data    = data0;
    end
  end

  // Pending mask: one-hot decode of each full slot's destination, OR-ed
  always_comb begin
    out_pending = '0;
    if (full0) begin
      out_pending[address0] = 1'b1;
    end
    if (full1) begin
      out_pending[address1] = 1'b1;
    end
  end

endmodule : register_file_write_arbiter
`default_nettype wire

// File: tb/tb_register_file_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_write_arbiter
//  Description : Directed self-checking bench for the register-file write
//                arbiter, with a behavioural register file on the write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_write_arbiter;

  localparam int W         = 16;
  localparam int ADDR_BITS = 4;
  localparam int NUM_REGS  = 16;

  logic                 clk;
  logic                 reset;
  logic                 inp_valid0, inp_valid1;
  logic                 out_ready0, out_ready1;
  logic [ADDR_BITS-1:0] inp_address0, inp_address1;
  logic [W-1:0]         inp_data0, inp_data1;
  logic                 out_write_enable;
  logic [ADDR_BITS-1:0] out_write_address;
  logic [W-1:0]         out_write_data;
  logic                 out_grant;
  logic [NUM_REGS-1:0]  out_pending;

  logic [W-1:0] mem [NUM_REGS];

  int checks;
  int failures;

  register_file_write_arbiter #(
    .W         (W),
    .ADDR_BITS (ADDR_BITS),
    .NUM_REGS  (NUM_REGS)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .inp_valid0        (inp_valid0),
    .out_ready0        (out_ready0),
    .inp_address0      (inp_address0),
    .inp_data0         (inp_data0),
    .inp_valid1        (inp_valid1),
    .out_ready1        (out_ready1),
    .inp_address1      (inp_address1),
    .inp_data1         (inp_data1),
    .out_write_enable  (out_write_enable),
    .out_write_address (out_write_address),
    .out_write_data    (out_write_data),
    .out_grant         (out_grant),
    .out_pending       (out_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural register file on the arbiter's write port
  always @(posedge clk) begin
    if (out_write_enable) begin
      mem[out_write_address] <= out_write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_we"},      32'(out_write_enable),  32'h0);
    chk({tag, "_addr"},    32'(out_write_address), 32'h0);
    chk({tag, "_data"},    32'(out_write_data),    32'h0);
    chk({tag, "_grant"},   32'(out_grant),         32'h0);
    chk({tag, "_pending"}, 32'(out_pending),       32'h0);
  endtask

  task automatic chk_write(input string tag, input logic g, input logic [3:0] a, input logic [15:0] d);
    chk({tag, "_we"},    32'(out_write_enable),  32'h1);
    chk({tag, "_grant"}, 32'(out_grant),         32'(g));
    chk({tag, "_addr"},  32'(out_write_address), 32'(a));
    chk({tag, "_data"},  32'(out_write_data),    32'(d));
  endtask

  initial begin
    int n0, n1;
    logic hs0, hs1;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < NUM_REGS; i++) mem[i] = '0;
    reset        = 1'b1;
    inp_valid0   = 1'b0;
    inp_valid1   = 1'b0;
    inp_address0 = '0;
    inp_address1 = '0;
    inp_data0    = '0;
    inp_data1    = '0;

    // Reset state
    #2;
    chk_idle("rst");
    chk("rst_ready0", 32'(out_ready0), 32'h1);
    chk("rst_ready1", 32'(out_ready1), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Single write from port 0: reg 2 = ABCD
    inp_valid0 = 1'b1; inp_address0 = 4'd2; inp_data0 = 16'hABCD;
    step();
    inp_valid0 = 1'b0;
    chk_write("t1", 1'b0, 4'd2, 16'hABCD);
    chk("t1_pending", 32'(out_pending), 32'h0004);
    step();
    chk_idle("t1_after");
    chk("t1_mem2", 32'(mem[2]), 32'hABCD);

    // Both ports to reg 5 on the same edge: port 0 first, port 1 last
    inp_valid0 = 1'b1; inp_address0 = 4'd5; inp_data0 = 16'h0001;
    inp_valid1 = 1'b1; inp_address1 = 4'd5; inp_data1 = 16'h0002;
    step();
    inp_valid0 = 1'b0; inp_valid1 = 1'b0;
    chk_write("t2a", 1'b0, 4'd5, 16'h0001);
    chk("t2a_pending", 32'(out_pending), 32'h0020);
    chk("t2a_ready0", 32'(out_ready0), 32'h1);
    chk("t2a_ready1", 32'(out_ready1), 32'h0);
    step();
    chk_write("t2b", 1'b1, 4'd5, 16'h0002);
    chk("t2b_pending", 32'(out_pending), 32'h0020);
    step();
    chk_idle("t2_after");
    chk("t2_mem5", 32'(mem[5]), 32'h0002);

    // Both ports stream for 8 edges: grants alternate 0,1,0,1...
    n0 = 0; n1 = 0;
    inp_valid0 = 1'b1; inp_address0 = 4'd7; inp_data0 = 16'h1000;
    inp_valid1 = 1'b1; inp_address1 = 4'd8; inp_data1 = 16'h2000;
    for (int k = 1; k <= 9; k++) begin
      hs0 = inp_valid0 && out_ready0;
      hs1 = inp_valid1 && out_ready1;
      step();
      if (hs0) n0++;
      if (hs1) n1++;
      inp_data0 = 16'(16'h1000 + n0);
      inp_data1 = 16'(16'h2000 + n1);
      if (k == 8) begin
        inp_valid0 = 1'b0;
        inp_valid1 = 1'b0;
      end
      if (k % 2 == 1) begin
        chk_write($sformatf("t3_c%0d", k), 1'b0, 4'd7, 16'(16'h1000 + (k - 1) / 2));
      end else begin
        chk_write($sformatf("t3_c%0d", k), 1'b1, 4'd8, 16'(16'h2000 + k / 2 - 1));
      end
      chk($sformatf("t3_c%0d_ready0", k), 32'(out_ready0), 32'(k % 2 == 1));
      chk($sformatf("t3_c%0d_ready1", k), 32'(out_ready1), 32'((k % 2 == 0) || (k == 9)));
    end
    chk("t3_n0", 32'(n0), 32'd5);
    chk("t3_n1", 32'(n1), 32'd4);
    step();
    chk_idle("t3_after");
    chk("t3_mem7", 32'(mem[7]), 32'h1004);
    chk("t3_mem8", 32'(mem[8]), 32'h2003);

    // Slot 1 waits behind slot 0, then beats a newer port 0 entry
    inp_valid0 = 1'b1; inp_address0 = 4'd3; inp_data0 = 16'h0A0A;
    inp_valid1 = 1'b1; inp_address1 = 4'd4; inp_data1 = 16'h0B0B;
    step();
    inp_valid1 = 1'b0;
    inp_data0  = 16'h0C0C;
    chk_write("t4a", 1'b0, 4'd3, 16'h0A0A);
    step();
    inp_valid0 = 1'b0;
    chk_write("t4b", 1'b1, 4'd4, 16'h0B0B);
    chk("t4b_pending", 32'(out_pending), 32'h0018);
    step();
    chk_write("t4c", 1'b0, 4'd3, 16'h0C0C);
    step();
    chk_idle("t4_after");
    chk("t4_mem3", 32'(mem[3]), 32'h0C0C);
    chk("t4_mem4", 32'(mem[4]), 32'h0B0B);

    // Port 0 streams alone to every register, data = address + 1
    inp_valid0 = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      inp_address0 = 4'(i);
      inp_data0    = 16'(i + 1);
      chk($sformatf("t5_ready0_%0d", i), 32'(out_ready0), 32'h1);
      step();
      chk_write($sformatf("t5_w%0d", i), 1'b0, 4'(i), 16'(i + 1));
    end
    inp_valid0 = 1'b0;
    step();
    chk_idle("t5_after");
    for (int i = 0; i < NUM_REGS; i++) begin
      chk($sformatf("t5_mem%0d", i), 32'(mem[i]), 32'(i + 1));
    end

    // Asynchronous reset between edges with both slots full
    inp_valid0 = 1'b1; inp_address0 = 4'd9;  inp_data0 = 16'h1111;
    inp_valid1 = 1'b1; inp_address1 = 4'd10; inp_data1 = 16'h2222;
    step();
    inp_valid0 = 1'b0; inp_valid1 = 1'b0;
    chk("t6_pending_pre", 32'(out_pending), 32'h0600);
    #2;
    reset = 1'b1;
    #1;
    chk_idle("t6_rst");
    step();
    chk_idle("t6_rst_edge");
    @(negedge clk);
    reset = 1'b0;
    step();
    chk_idle("t6_after");
    chk("t6_ready0", 32'(out_ready0), 32'h1);
    chk("t6_ready1", 32'(out_ready1), 32'h1);
    chk("t6_mem9",  32'(mem[9]),  32'h000A);
    chk("t6_mem10", 32'(mem[10]), 32'h000B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_register_file_write_arbiter
`default_nettype wire
